pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and flush (bubble-insert) controls of the PC and of the IF/ID, ID/EX, EX/M and M/WB registers.
- Resolves three events, in fixed priority: data-memory wait states, control redirects resolved in the M stage (taken branch or jump), and load-use hazards detected in ID.
- Also watches data-memory latency and raises a sticky error on timeout.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/hazard_detect.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-control types and constants
package pipe_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } reg_ctl_t;

  // A flush wins over the enable, so a bubble is a flushed load of all-zero controls
  localparam reg_ctl_t CTL_RUN    = '{en: 1'b1, flush: 1'b0};
  localparam reg_ctl_t CTL_HOLD   = '{en: 1'b0, flush: 1'b0};
  localparam reg_ctl_t CTL_BUBBLE = '{en: 1'b1, flush: 1'b1};
  localparam reg_ctl_t CTL_RESET  = '{en: 1'b0, flush: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard comparison between ID sources and EX load
module hazard_detect #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_Regwr,
  input  logic          ex_MemtoReg,
  output logic          lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_use_rs && (id_rs == ex_rd);
  assign rt_hit = id_use_rt && (id_rt == ex_rd);
  // Register 0 is hardwired, so a load into it never creates a dependency
  assign lu = ex_MemtoReg && ex_Regwr && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush sequencer; optional PIPE_PERF_CNT_EN counters
module pipe_hazard_ctrl #(
  parameter int REG_AW      = pipe_pkg::REG_AW,
  parameter int MEM_TIMEOUT = 16
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic              CLK,
  input  logic              Resetn,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_Regwr,
  input  logic              ex_MemtoReg,
  input  logic              m_Branch_taken,
  input  logic              m_Jump,
  input  logic              m_MemRd,
  input  logic              m_MemWr,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exm_en,
  output logic              mwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exm_flush,
  output logic              mwb_flush,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
`endif
  output logic              mem_err
);

  import pipe_pkg::*;

  localparam int WCW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           mem_err_q, mem_err_d;
  logic           lu, redirect, hold, redirect_taken;
  reg_ctl_t       pc_c, ifid_c, idex_c, exm_c, mwb_c;

  hazard_detect #(.AW(REG_AW)) u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_rd       (ex_rd),
    .ex_Regwr    (ex_Regwr),
    .ex_MemtoReg (ex_MemtoReg),
    .lu          (lu)
  );

  assign redirect = m_Branch_taken || m_Jump;
  // Once waiting, only dmem_ready ends the stall regardless of the M-stage request bits
  assign hold = (state_q == MEM_WAIT) ? !dmem_ready
                                      : ((m_MemRd || m_MemWr) && !dmem_ready);

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    mem_err_d      = mem_err_q;
    redirect_taken = 1'b0;
    pc_c           = CTL_RUN;
    ifid_c         = CTL_RUN;
    idex_c         = CTL_RUN;
    exm_c          = CTL_RUN;
    mwb_c          = CTL_RUN;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (hold) begin
          pc_c   = CTL_HOLD;
          ifid_c = CTL_HOLD;
          idex_c = CTL_HOLD;
          exm_c  = CTL_HOLD;
          mwb_c  = CTL_BUBBLE;
          if (state_q == RUN) begin
            state_d = MEM_WAIT;
            wait_d  = WCW'(1);
          end else if (wait_q == WAIT_LAST) begin
            state_d   = MEM_ERR;
            mem_err_d = 1'b1;
          end else begin
            wait_d = wait_q + WCW'(1);
          end
        end else begin
          state_d = RUN;
          wait_d  = '0;
          if (redirect) begin
            redirect_taken = 1'b1;
            ifid_c         = CTL_BUBBLE;
            idex_c         = CTL_BUBBLE;
            exm_c          = CTL_BUBBLE;
          end else if (lu) begin
            pc_c   = CTL_HOLD;
            ifid_c = CTL_HOLD;
            idex_c = CTL_BUBBLE;
          end
        end
      end
      default: begin
        pc_c   = CTL_HOLD;
        ifid_c = CTL_HOLD;
        idex_c = CTL_HOLD;
        exm_c  = CTL_HOLD;
        mwb_c  = CTL_HOLD;
      end
    endcase
    if (!Resetn) begin
      pc_c   = CTL_RESET;
      ifid_c = CTL_RESET;
      idex_c = CTL_RESET;
      exm_c  = CTL_RESET;
      mwb_c  = CTL_RESET;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Resetn) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge CLK) begin
    if (!Resetn) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_c.en && state_q != MEM_ERR && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
      if (redirect_taken && flush_q != '1)
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

  assign pc_en      = pc_c.en;
  assign ifid_en    = ifid_c.en;
  assign idex_en    = idex_c.en;
  assign exm_en     = exm_c.en;
  assign mwb_en     = mwb_c.en;
  assign ifid_flush = ifid_c.flush;
  assign idex_flush = idex_c.flush;
  assign exm_flush  = exm_c.flush;
  assign mwb_flush  = mwb_c.flush;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       Resetn;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_Regwr, ex_MemtoReg;
  logic       m_Branch_taken, m_Jump, m_MemRd, m_MemWr, dmem_ready;
  logic       pc_en, ifid_en, idex_en, exm_en, mwb_en;
  logic       ifid_flush, idex_flush, exm_flush, mwb_flush, mem_err;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // {pc,ifid,idex,exm,mwb enables ; ifid,idex,exm,mwb flushes ; mem_err}
  localparam logic [9:0] V_RST  = 10'b00000_1111_0;
  localparam logic [9:0] V_RUN  = 10'b11111_0000_0;
  localparam logic [9:0] V_REDIR = 10'b11111_1110_0;
  localparam logic [9:0] V_BUSY = 10'b00001_0001_0;
  localparam logic [9:0] V_ERR  = 10'b00000_0000_1;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(4)) dut (
    .CLK(CLK), .Resetn(Resetn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_Regwr(ex_Regwr), .ex_MemtoReg(ex_MemtoReg),
    .m_Branch_taken(m_Branch_taken), .m_Jump(m_Jump),
    .m_MemRd(m_MemRd), .m_MemWr(m_MemWr), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exm_en(exm_en), .mwb_en(mwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exm_flush(exm_flush), .mwb_flush(mwb_flush),
`ifdef PIPE_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .mem_err(mem_err)
  );

  function automatic logic [9:0] outs();
    return {pc_en, ifid_en, idex_en, exm_en, mwb_en,
            ifid_flush, idex_flush, exm_flush, mwb_flush, mem_err};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 0; id_use_rt = 0; ex_Regwr = 0; ex_MemtoReg = 0;
    m_Branch_taken = 0; m_Jump = 0; m_MemRd = 0; m_MemWr = 0; dmem_ready = 0;
  endtask

  initial begin
    clear_inputs();
    Resetn = 0;
    step();
    check("rst_cyc1", outs(), V_RST);
    step();
    check("rst_cyc2", outs(), V_RST);
`ifdef PIPE_PERF_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
`endif
    Resetn = 1; #1;
    check("run_first", outs(), V_RUN);
    step();
    check("run_second", outs(), V_RUN);

    // Load-use on rs
    ex_MemtoReg = 1; ex_Regwr = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1; #1;
    check("lu_pc_en", pc_en, 0);
    check("lu_ifid_en", ifid_en, 0);
    check("lu_idex_flush", idex_flush, 1);
    check("lu_exm_en", exm_en, 1);
    check("lu_mwb_en", mwb_en, 1);
    step();
    ex_MemtoReg = 0; #1;
    check("lu_released", outs(), V_RUN);

    // Load-use on rt, then same register without the use flag
    ex_MemtoReg = 1; ex_rd = 7; id_rt = 7; id_use_rt = 1; id_use_rs = 0; #1;
    check("lu_rt_pc_en", pc_en, 0);
    id_use_rt = 0; #1;
    check("lu_rt_unused", outs(), V_RUN);

    // Register 0 is never a hazard
    ex_rd = 0; id_rs = 0; id_use_rs = 1; #1;
    check("lu_r0", outs(), V_RUN);
    step();

    // Redirect outranks a simultaneous load-use
    ex_rd = 5; id_rs = 5; m_Branch_taken = 1; #1;
    check("branch_over_lu", outs(), V_REDIR);
    step();
    clear_inputs(); m_Jump = 1; #1;
    check("jump", outs(), V_REDIR);
    step();
    clear_inputs();

    // Load waits three cycles then completes
    m_MemRd = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("wait3_busy%0d", i), outs(), V_BUSY);
      step();
    end
    dmem_ready = 1; #1;
    check("wait3_done", outs(), V_RUN);
    step();
    clear_inputs(); #1;
    check("wait3_back_run", outs(), V_RUN);

    // Pending jump honoured on the completing cycle of a store
    m_MemWr = 1; m_Jump = 1; #1;
    check("st_busy", outs(), V_BUSY);
    step();
    dmem_ready = 1; #1;
    check("st_done_redirect", outs(), V_REDIR);
    step();
    clear_inputs(); #1;
    check("st_back_run", outs(), V_RUN);

    // Timeout with MEM_TIMEOUT=4
    m_MemRd = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("to_busy%0d", i), outs(), V_BUSY);
      step();
    end
    check("to_err", outs(), V_ERR);
    clear_inputs(); dmem_ready = 1; #1;
    check("to_err_frozen", outs(), V_ERR);
    step();
    check("to_err_sticky", outs(), V_ERR);
    Resetn = 0;
    step();
    check("to_reset", outs(), V_RST);
    Resetn = 1; #1;
    check("to_after_reset", outs(), V_RUN);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
